// File: rtl/lfsr_checker.sv
// Receive-side LFSR integrity monitor: self-synchronises a local Galois LFSR
// to the incoming word stream, then flags and counts words that deviate from it.
module lfsr_checker #(
    parameter int              WIDTH    = 4,
    parameter logic [WIDTH-1:0] TAPS    = 4'b0101,
    parameter int              LOCK_CNT = 3,
    parameter int              LOSS_CNT = 4,
    parameter int              CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic             clear_cnt,
    output logic             locked,
    output logic             err_pulse,
    output logic             sync_loss,
    output logic [CNT_W-1:0] err_count
);

    localparam int MW = $clog2(LOCK_CNT + 1);
    localparam int BW = $clog2(LOSS_CNT + 1);

    typedef enum logic {HUNT, LOCKED} state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] pred, pred_n;
    logic             pred_valid, pred_valid_n;
    logic [MW-1:0]    match_cnt, match_n;
    logic [BW-1:0]    bad_cnt, bad_n;
    logic             err_n, loss_n, inc;

    function automatic logic [WIDTH-1:0] lfsr_next(input logic [WIDTH-1:0] s);
        return {s[WIDTH-2:0], 1'b0} ^ (s[WIDTH-1] ? TAPS : '0);
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= HUNT;
            pred       <= '0;
            pred_valid <= 1'b0;
            match_cnt  <= '0;
            bad_cnt    <= '0;
            err_pulse  <= 1'b0;
            sync_loss  <= 1'b0;
            err_count  <= '0;
        end else begin
            state      <= state_n;
            pred       <= pred_n;
            pred_valid <= pred_valid_n;
            match_cnt  <= match_n;
            bad_cnt    <= bad_n;
            err_pulse  <= err_n;
            sync_loss  <= loss_n;
            // clear wins over a coincident error; the pulse still fires
            if (clear_cnt)
                err_count <= '0;
            else if (inc && (err_count != '1))
                err_count <= err_count + 1'b1;
        end
    end

    always_comb begin
        state_n      = state;
        pred_n       = pred;
        pred_valid_n = pred_valid;
        match_n      = match_cnt;
        bad_n        = bad_cnt;
        err_n        = 1'b0;
        loss_n       = 1'b0;
        inc          = 1'b0;
        if (in_valid) begin
            case (state)
                HUNT: begin
                    // an all-zero word never seeds a prediction (lock-up state)
                    pred_n       = lfsr_next(in_data);
                    pred_valid_n = (in_data != '0);
                    if (pred_valid && (in_data == pred)) begin
                        if (match_cnt == MW'(LOCK_CNT - 1)) begin
                            state_n = LOCKED;
                            match_n = '0;
                            bad_n   = '0;
                        end else begin
                            match_n = match_cnt + 1'b1;
                        end
                    end else begin
                        match_n = '0;
                    end
                end
                LOCKED: begin
                    // flywheel: prediction advances on its own, never reseeded
                    pred_n = lfsr_next(pred);
                    if (in_data != pred) begin
                        err_n = 1'b1;
                        inc   = 1'b1;
                        if (bad_cnt == BW'(LOSS_CNT - 1)) begin
                            state_n      = HUNT;
                            loss_n       = 1'b1;
                            pred_valid_n = 1'b0;
                            match_n      = '0;
                            bad_n        = '0;
                        end else begin
                            bad_n = bad_cnt + 1'b1;
                        end
                    end else begin
                        bad_n = '0;
                    end
                end
                default: state_n = HUNT;
            endcase
        end
    end

    always_comb begin
        locked = (state == LOCKED);
    end

endmodule

// File: tb/tb_lfsr_checker.sv
// Directed bench for lfsr_checker: lock, errors, loss, zero/gap handling,
// counter saturation (CNT_W=3 instance) and asynchronous reset.
module tb_lfsr_checker;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [3:0]  in_data;
    logic        clear_cnt;
    logic        locked, err_pulse, sync_loss;
    logic [15:0] err_count;
    logic        locked3, err_pulse3, sync_loss3;
    logic [2:0]  err_count3;

    int n_cmp = 0;
    int n_bad = 0;
    int idx;
    logic [3:0] seq [6];

    always #5 clk = ~clk;

    lfsr_checker dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .clear_cnt(clear_cnt), .locked(locked), .err_pulse(err_pulse),
        .sync_loss(sync_loss), .err_count(err_count)
    );

    lfsr_checker #(.CNT_W(3)) dut3 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .clear_cnt(clear_cnt), .locked(locked3), .err_pulse(err_pulse3),
        .sync_loss(sync_loss3), .err_count(err_count3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [3:0] w);
        in_valid = 1'b1;
        in_data  = w;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        #2;
        rst = 1'b0;
        idle(1);
    endtask

    initial begin
        seq[0] = 4'b0101; seq[1] = 4'b1010; seq[2] = 4'b0001;
        seq[3] = 4'b0010; seq[4] = 4'b0100; seq[5] = 4'b1000;
        rst = 1'b1; in_valid = 1'b0; in_data = '0; clear_cnt = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_locked", locked, 0);
        chk("rst_err_pulse", err_pulse, 0);
        chk("rst_sync_loss", sync_loss, 0);
        chk("rst_err_count", err_count, 0);
        rst = 1'b0;
        idle(1);

        // lock acquisition
        send(4'b0001); chk("lock_w1_locked", locked, 0);
        send(4'b0010); chk("lock_w2_pulse", err_pulse, 0);
        send(4'b0100); chk("lock_w3_locked", locked, 0);
        send(4'b1000); chk("lock_w4_locked", locked, 1);
        chk("lock_count", err_count, 0);
        chk("lock_pulse", err_pulse, 0);

        // single error, flywheel recovers
        send(4'b0111); chk("single_pulse", err_pulse, 1);
        chk("single_count", err_count, 1);
        chk("single_locked", locked, 1);
        chk("single_noloss", sync_loss, 0);
        send(4'b1010); chk("fly1_pulse", err_pulse, 0);
        send(4'b0001); chk("fly2_pulse", err_pulse, 0);
        chk("fly_count", err_count, 1);

        // clear on an idle cycle
        clear_cnt = 1'b1; idle(1); clear_cnt = 1'b0;
        chk("clear_idle", err_count, 0);

        // loss of sync
        send(4'b1111); chk("loss1_pulse", err_pulse, 1);
        send(4'b1111); chk("loss2_locked", locked, 1);
        send(4'b1111); chk("loss3_noloss", sync_loss, 0);
        send(4'b1111); chk("loss4_pulse", err_pulse, 1);
        chk("loss4_sync_loss", sync_loss, 1);
        chk("loss4_locked", locked, 0);
        chk("loss4_count", err_count, 4);
        idle(1);
        chk("loss_stall_pulse", err_pulse, 0);
        chk("loss_stall_sync", sync_loss, 0);
        send(4'b0001); send(4'b0010); send(4'b0100);
        chk("relock_pre", locked, 0);
        send(4'b1000); chk("relock", locked, 1);

        // zero words and gaps in HUNT
        pulse_rst();
        chk("zrst_locked", locked, 0);
        send(4'b0000); send(4'b0000); send(4'b0000); send(4'b0000);
        chk("zero_nolock", locked, 0);
        send(4'b0001); idle(3);
        send(4'b0010); idle(3);
        send(4'b0100); idle(3);
        chk("gap_pre", locked, 0);
        send(4'b1000); chk("gap_lock", locked, 1);
        idle(3);
        chk("gap_locked_hold", locked, 1);
        chk("gap_pulse", err_pulse, 0);

        // saturation: 9 isolated errors, dut3 saturates at 7
        idx = 0;
        for (int e = 1; e <= 9; e++) begin
            send(4'b1111); idx = (idx + 1) % 6;
            chk("sat_pulse", err_pulse3, 1);
            if (e == 7 || e == 9) chk("sat_count3", err_count3, 7);
            send(seq[idx]); idx = (idx + 1) % 6;
            chk("sat_good_pulse", err_pulse3, 0);
        end
        chk("sat_count16", err_count, 9);
        chk("sat_locked", locked3, 1);

        // clear coincident with an error
        clear_cnt = 1'b1; send(4'b1111); clear_cnt = 1'b0; idx = (idx + 1) % 6;
        chk("clr_err_count", err_count, 0);
        chk("clr_err_count3", err_count3, 0);
        chk("clr_err_pulse", err_pulse, 1);
        send(seq[idx]); idx = (idx + 1) % 6;

        // two errors then asynchronous reset mid-cycle
        send(4'b1111); idx = (idx + 1) % 6;
        send(seq[idx]); idx = (idx + 1) % 6;
        send(4'b1111); idx = (idx + 1) % 6;
        send(seq[idx]); idx = (idx + 1) % 6;
        chk("pre_arst_count", err_count, 2);
        chk("pre_arst_locked", locked, 1);
        #3; rst = 1'b1; #1;
        chk("arst_locked", locked, 0);
        chk("arst_count", err_count, 0);
        #1; rst = 1'b0;
        idle(1);
        send(seq[idx]); idx = (idx + 1) % 6;
        send(seq[idx]); idx = (idx + 1) % 6;
        send(seq[idx]); idx = (idx + 1) % 6;
        chk("arst_relock_pre", locked, 0);
        send(seq[idx]); idx = (idx + 1) % 6;
        chk("arst_relock", locked, 1);
        chk("arst_relock_count", err_count, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
